lut_factorial_dispatch: RTL

Request front-end that sits directly upstream of `lut_factorial_cond`. It buffers incoming factorial requests in a small FIFO and drives the core's `source_number_32b`/`start` inputs, one job at a time. It captures `factorial` when the core raises `output_ready` and presents each result on a valid/ready output port. Operands above 20 are rejected locally, because 21! does not fit in 64 bits. A watchdog times out a core that never answers.

---
 rtl/lut_factorial_dispatch.sv | 116 +++++++++++
 1 files changed

// File: rtl/lut_factorial_dispatch.sv
`timescale 1ns/1ps
// lut_factorial_dispatch: FIFO-buffered request front-end for lut_factorial_cond with local overflow reject and a watchdog.
// Ports:
//   clk_32b, rst_32b              clock, async active-high reset
//   req_valid/req_ready/req_number  request input (FIFO push)
//   source_number_32b, start      operand and one-cycle start pulse to the core
//   factorial, output_ready       core result and its level-valid
//   res_valid/res_ready           held result handshake
//   res_number, res_factorial     operand and n! (0 on overflow/timeout)
//   res_overflow, res_timeout     n > 20 rejected / core never answered
//   busy                          FSM not IDLE or FIFO non-empty
module lut_factorial_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk_32b,
  input  logic        rst_32b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_number,
  output logic [31:0] source_number_32b,
  output logic        start,
  input  logic [63:0] factorial,
  input  logic        output_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_number,
  output logic [63:0] res_factorial,
  output logic        res_overflow,
  output logic        res_timeout,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   cur_n;
  logic [WW-1:0] wd;
  logic          push, pop;
  logic [31:0]   head;
  assign req_ready = count != (AW + 1)'(DEPTH);
  assign busy      = state != IDLE || count != '0;
  assign push      = req_valid && req_ready;
  assign pop       = state == IDLE && count != '0 && !res_valid;
  assign head      = mem[rd_ptr];
  always_ff @(posedge clk_32b)
    if (push) mem[wr_ptr] <= req_number;
  always_ff @(posedge clk_32b or posedge rst_32b)
    if (rst_32b) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      cur_n             <= '0;
      wd                <= '0;
      source_number_32b <= '0;
      start             <= 1'b0;
      res_valid         <= 1'b0;
      res_number        <= '0;
      res_factorial     <= '0;
      res_overflow      <= 1'b0;
      res_timeout       <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      start  <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          cur_n <= head;
          if (head > 32'd20) begin
            res_number    <= head;
            res_factorial <= '0;
            res_overflow  <= 1'b1;
            res_timeout   <= 1'b0;
            res_valid     <= 1'b1;
            state         <= HOLD;
          end else begin
            source_number_32b <= head;
            start             <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: if (output_ready) begin
          res_number    <= cur_n;
          res_factorial <= factorial;
          res_overflow  <= 1'b0;
          res_timeout   <= 1'b0;
          res_valid     <= 1'b1;
          state         <= HOLD;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          // wd counts WAIT edges already spent; this edge is the TIMEOUT-th
          res_number    <= cur_n;
          res_factorial <= '0;
          res_overflow  <= 1'b0;
          res_timeout   <= 1'b1;
          res_valid     <= 1'b1;
          state         <= HOLD;
        end else begin
          wd <= wd + 1'b1;
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
